// File: rtl/board_char_mem_ctrl_if.sv
// ---------------------------------------------------------------------------
// board_char_mem_ctrl_if
//
// Groups the request/response signals of the board character memory
// controller into one bundle.
//   master : the side that drives requests (display reader, game logic, clear).
//   slave  : the memory controller itself.
//
// Signals
//   button_num          board dimension in fields per side
//   rd_en, rd_x, rd_y   display read request and field coordinates
//   rd_code, rd_valid   read field code and its qualifier (one cycle later)
//   wr_req, wr_x, wr_y, wr_code
//                       game write request, held until wr_ack
//   wr_ack, wr_err      write-done pulse and out-of-range flag
//   clr_start           board clear request pulse
//   busy, clr_done      clear in progress / clear finished pulse
// ---------------------------------------------------------------------------
interface board_char_mem_ctrl_if;
  logic [4:0] button_num;

  logic       rd_en;
  logic [4:0] rd_x;
  logic [4:0] rd_y;
  logic [3:0] rd_code;
  logic       rd_valid;

  logic       wr_req;
  logic [4:0] wr_x;
  logic [4:0] wr_y;
  logic [3:0] wr_code;
  logic       wr_ack;
  logic       wr_err;

  logic       clr_start;
  logic       busy;
  logic       clr_done;

  modport master (
    output button_num, rd_en, rd_x, rd_y, wr_req, wr_x, wr_y, wr_code, clr_start,
    input  rd_code, rd_valid, wr_ack, wr_err, busy, clr_done
  );

  modport slave (
    input  button_num, rd_en, rd_x, rd_y, wr_req, wr_x, wr_y, wr_code, clr_start,
    output rd_code, rd_valid, wr_ack, wr_err, busy, clr_done
  );
endinterface

// File: rtl/board_char_mem_ctrl.sv
// ---------------------------------------------------------------------------
// board_char_mem_ctrl
//
// Single-port 1024 x 4-bit character store for a square game board, addressed
// {y,x}. One access per cycle is arbitrated between three clients:
//   1. display reads      (highest)
//   2. clear-sweep writes (fills every field of an N x N board with HIDDEN_CODE)
//   3. game writes        (lowest, held by the requester until wr_ack)
//
// Optional feature (macro CHAR_MEM_STARVE_GUARD_EN): a write blocked by reads
// for STARVE_LIMIT consecutive cycles takes the next cycle away from the
// reader. Without the macro, reads always win.
//
// Parameters
//   STARVE_LIMIT  consecutive blocked cycles before a write is forced through
//   HIDDEN_CODE   code written to every field by a clear sweep
//
// Ports
//   clk   system clock
//   rst   synchronous, active-high reset; starts a clear sweep
//   bus   board_char_mem_ctrl_if.slave (read, write and clear channels)
// ---------------------------------------------------------------------------
module board_char_mem_ctrl #(
  parameter int unsigned STARVE_LIMIT = 64,
  parameter logic [3:0]  HIDDEN_CODE  = 4'hF
) (
  input  logic                 clk,
  input  logic                 rst,
  board_char_mem_ctrl_if.slave bus
);

`ifdef CHAR_MEM_STARVE_GUARD_EN
  localparam bit GUARD_EN = 1'b1;
`else
  localparam bit GUARD_EN = 1'b0;
`endif

  localparam int unsigned SW = $clog2(STARVE_LIMIT + 2);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  state_e     state_q, state_d;
  logic [4:0] n_q, n_d;
  logic [4:0] sx_q, sx_d;
  logic [4:0] sy_q, sy_d;

  logic [3:0] rd_code_q, rd_code_d;
  logic       rd_valid_q, rd_valid_d;
  logic       wr_ack_q, wr_ack_d;
  logic       wr_err_q, wr_err_d;
  logic       clr_done_q, clr_done_d;

  logic [SW-1:0] starve_q, starve_d;

  logic [3:0] mem_q [1024];
  logic       mem_we;
  logic [9:0] mem_waddr;
  logic [3:0] mem_wdata;

  logic wr_in_range;
  logic game_pend;
  logic game_err;
  logic sweep_pend;
  logic sweep_last;
  logic wr_pend;
  logic starve_hit;
  logic force_wr;
  logic rd_grant;
  logic sweep_wr;
  logic game_wr;
  logic commit;

  // Request qualification. The wr_ack_q term stops a held wr_req from being
  // taken a second time in the cycle its ack is being presented.
  assign wr_in_range = (bus.wr_x < bus.button_num) && (bus.wr_y < bus.button_num);
  assign game_pend   = (state_q == IDLE) && !bus.clr_start && bus.wr_req &&
                       !wr_ack_q && wr_in_range;
  assign game_err    = (state_q == IDLE) && !bus.clr_start && bus.wr_req &&
                       !wr_ack_q && !wr_in_range;
  assign sweep_pend  = (state_q == CLEAR) && !bus.clr_start && (n_q != 5'd0);
  assign sweep_last  = (sx_q == n_q - 5'd1) && (sy_q == n_q - 5'd1);
  assign wr_pend     = sweep_pend || game_pend;

  // Arbitration: a read wins unless the starve guard has fired.
  assign starve_hit = (starve_q == SW'(STARVE_LIMIT));
  assign force_wr   = GUARD_EN && starve_hit && wr_pend;
  assign rd_grant   = bus.rd_en && !force_wr;
  assign sweep_wr   = sweep_pend && !rd_grant;
  assign game_wr    = game_pend && !rd_grant;
  assign commit     = sweep_wr || game_wr;

  // Starve counter: consecutive cycles a pending write lost to a read.
  always_comb begin
    starve_d = starve_q;
    if (commit) begin
      starve_d = '0;
    end else if (wr_pend && rd_grant && !starve_hit) begin
      starve_d = starve_q + SW'(1);
    end
  end

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    sx_d       = sx_q;
    sy_d       = sy_q;
    rd_code_d  = rd_code_q;
    rd_valid_d = 1'b0;
    wr_ack_d   = 1'b0;
    wr_err_d   = 1'b0;
    clr_done_d = 1'b0;
    mem_we     = 1'b0;
    mem_waddr  = {sy_q, sx_q};
    mem_wdata  = HIDDEN_CODE;

    if (rd_grant) begin
      rd_code_d  = mem_q[{bus.rd_y, bus.rd_x}];
      rd_valid_d = 1'b1;
    end

    if (bus.clr_start) begin
      // A new clear (also mid-sweep) restarts at (0,0) with a fresh N.
      state_d = CLEAR;
      n_d     = bus.button_num;
      sx_d    = 5'd0;
      sy_d    = 5'd0;
    end else if (state_q == CLEAR) begin
      if (n_q == 5'd0) begin
        state_d    = IDLE;
        clr_done_d = 1'b1;
      end else if (sweep_wr) begin
        mem_we = 1'b1;
        if (sweep_last) begin
          state_d    = IDLE;
          clr_done_d = 1'b1;
        end else if (sx_q == n_q - 5'd1) begin
          sx_d = 5'd0;
          sy_d = sy_q + 5'd1;
        end else begin
          sx_d = sx_q + 5'd1;
        end
      end
    end else begin
      if (game_wr) begin
        mem_we    = 1'b1;
        mem_waddr = {bus.wr_y, bus.wr_x};
        mem_wdata = bus.wr_code;
        wr_ack_d  = 1'b1;
      end else if (game_err) begin
        // Out-of-range writes need no storage slot, so they never wait.
        wr_ack_d = 1'b1;
        wr_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= CLEAR;
      n_q        <= bus.button_num;
      sx_q       <= 5'd0;
      sy_q       <= 5'd0;
      rd_code_q  <= 4'h0;
      rd_valid_q <= 1'b0;
      wr_ack_q   <= 1'b0;
      wr_err_q   <= 1'b0;
      clr_done_q <= 1'b0;
      starve_q   <= '0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      sx_q       <= sx_d;
      sy_q       <= sy_d;
      rd_code_q  <= rd_code_d;
      rd_valid_q <= rd_valid_d;
      wr_ack_q   <= wr_ack_d;
      wr_err_q   <= wr_err_d;
      clr_done_q <= clr_done_d;
      starve_q   <= starve_d;
    end
  end

  // Storage has no reset; its contents come from the post-reset sweep.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  // Outputs are forced quiet for the whole cycle rst is high, not just after
  // the reset edge.
  assign bus.rd_code  = rst ? 4'h0 : rd_code_q;
  assign bus.rd_valid = !rst && rd_valid_q;
  assign bus.wr_ack   = !rst && wr_ack_q;
  assign bus.wr_err   = !rst && wr_err_q;
  assign bus.clr_done = !rst && clr_done_q;
  assign bus.busy     = rst || (state_q == CLEAR);

endmodule

// File: tb/tb_board_char_mem_ctrl.sv
module tb_board_char_mem_ctrl;
  localparam int STARVE = 64;

`ifdef CHAR_MEM_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  board_char_mem_ctrl_if bus ();

  board_char_mem_ctrl #(
    .STARVE_LIMIT(STARVE),
    .HIDDEN_CODE (4'hF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_chk = 0;
  int n_err = 0;

  // Reference board contents, indexed {y,x}.
  logic [3:0] model [1024];
  logic [3:0] last_rc;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [9:0] addr(input int x, input int y);
    return {y[4:0], x[4:0]};
  endfunction

  task automatic sweep_model(input int n, input int fields);
    for (int f = 0; f < fields; f++) model[addr(f % n, f / n)] = 4'hF;
  endtask

  task automatic wait_clr(input int limit, output int cyc, output int busy_low);
    cyc = -1;
    busy_low = 0;
    for (int k = 1; k <= limit; k++) begin
      tick();
      if (bus.clr_done) begin
        cyc = k;
        break;
      end
      if (!bus.busy) busy_low++;
    end
  endtask

  task automatic do_reset(input int n);
    int cyc, bl;
    bus.button_num = 5'(n);
    rst = 1'b1;
    tick();
    tick();
    check_eq("rst_rd_valid", bus.rd_valid, 0);
    check_eq("rst_rd_code", bus.rd_code, 0);
    check_eq("rst_wr_ack", bus.wr_ack, 0);
    check_eq("rst_wr_err", bus.wr_err, 0);
    check_eq("rst_clr_done", bus.clr_done, 0);
    check_eq("rst_busy", bus.busy, 1);
    rst = 1'b0;
    wait_clr(2000, cyc, bl);
    check_eq("rst_sweep_cycles", cyc, n * n);
    check_eq("rst_busy_dropped_early", bl, 0);
    check_eq("rst_busy_after_done", bus.busy, 0);
    sweep_model(n, n * n);
    last_rc = 4'h0;
  endtask

  task automatic do_read(input int x, input int y);
    logic [3:0] e;
    e = model[addr(x, y)];
    bus.rd_en = 1'b1;
    bus.rd_x = 5'(x);
    bus.rd_y = 5'(y);
    tick();
    check_eq("rd_valid", bus.rd_valid, 1);
    check_eq("rd_code", bus.rd_code, e);
    bus.rd_en = 1'b0;
    last_rc = e;
  endtask

  task automatic do_write(input int x, input int y, input logic [3:0] c, input logic e_err);
    bus.wr_req = 1'b1;
    bus.wr_x = 5'(x);
    bus.wr_y = 5'(y);
    bus.wr_code = c;
    tick();
    check_eq("wr_ack", bus.wr_ack, 1);
    check_eq("wr_err", bus.wr_err, e_err);
    bus.wr_req = 1'b0;
    if (!e_err && bus.wr_ack) model[addr(x, y)] = c;
    tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int ack_k, done_k, inval, pre_ack, cyc, bl;
    bus.button_num = 5'd0;
    bus.rd_en = 1'b0;
    bus.rd_x = 5'd0;
    bus.rd_y = 5'd0;
    bus.wr_req = 1'b0;
    bus.wr_x = 5'd0;
    bus.wr_y = 5'd0;
    bus.wr_code = 4'h0;
    bus.clr_start = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 1024; i++) model[i] = 4'h0;
    last_rc = 4'h0;

    // Fill the reachable board area so every later read has a known value.
    do_reset(31);

    // Reset with a 10x10 board, then read the far corner.
    do_reset(10);
    do_read(9, 9);
    check_eq("clr_done_single_pulse", bus.clr_done, 0);
    tick();
    check_eq("rd_valid_idle", bus.rd_valid, 0);
    check_eq("rd_code_hold", bus.rd_code, last_rc);

    // Plain write then read back.
    do_write(3, 4, 4'h5, 1'b0);
    do_read(3, 4);

    // Out-of-range write leaves storage untouched.
    do_write(12, 0, 4'h3, 1'b1);
    do_read(12, 0);

    // Write against a continuous read stream.
    bus.rd_en = 1'b1;
    bus.rd_x = 5'd0;
    bus.rd_y = 5'd0;
    bus.wr_req = 1'b1;
    bus.wr_x = 5'd1;
    bus.wr_y = 5'd1;
    bus.wr_code = 4'h7;
    ack_k = 0;
    inval = 0;
    done_k = 0;
    for (int k = 1; k <= 80; k++) begin
      tick();
      if (!bus.rd_valid) begin
        inval++;
        done_k = k;
      end
      if (bus.wr_ack) begin
        ack_k = k;
        bus.wr_req = 1'b0;
        model[addr(1, 1)] = 4'h7;
      end
    end
    check_eq("starve_ack_cycle", ack_k, GUARD ? STARVE + 1 : 0);
    check_eq("starve_invalid_reads", inval, GUARD ? 1 : 0);
    check_eq("starve_invalid_at", done_k, GUARD ? STARVE + 1 : 0);
    bus.rd_en = 1'b0;
    tick();
    check_eq("starve_ack_after_rd_drop", bus.wr_ack, GUARD ? 0 : 1);
    if (bus.wr_ack) model[addr(1, 1)] = 4'h7;
    bus.wr_req = 1'b0;
    tick();
    do_read(1, 1);

    // Randomized read/write traffic against the model.
    begin
      bit pend, cool, pe;
      int px, py, blk, rx, ry;
      logic [3:0] pc, exp_rc;
      logic exp_ack, exp_err, exp_rv;
      pend = 0;
      cool = 0;
      pe = 0;
      px = 0;
      py = 0;
      pc = 4'h0;
      blk = 0;
      bus.button_num = 5'd10;
      for (int i = 0; i < 400; i++) begin
        rx = int'($urandom % 31);
        ry = int'($urandom % 31);
        bus.rd_x = 5'(rx);
        bus.rd_y = 5'(ry);
        bus.rd_en = 1'($urandom % 2);
        if (!pend && !cool && ($urandom % 3 == 0)) begin
          pend = 1;
          px = int'($urandom % 16);
          py = int'($urandom % 16);
          pc = 4'($urandom);
          pe = (px >= 10) || (py >= 10);
          blk = 0;
          bus.wr_req = 1'b1;
          bus.wr_x = 5'(px);
          bus.wr_y = 5'(py);
          bus.wr_code = pc;
        end
        cool = 0;
        exp_ack = 1'b0;
        exp_err = 1'b0;
        exp_rv = bus.rd_en;
        if (pend) begin
          if (pe) begin
            exp_ack = 1'b1;
            exp_err = 1'b1;
          end else if (!bus.rd_en || (GUARD && blk == STARVE)) begin
            exp_ack = 1'b1;
            exp_rv = 1'b0;
          end else begin
            blk++;
          end
        end
        exp_rc = exp_rv ? model[addr(rx, ry)] : last_rc;
        tick();
        check_eq("rnd_wr_ack", bus.wr_ack, exp_ack);
        check_eq("rnd_wr_err", bus.wr_err, exp_err);
        check_eq("rnd_rd_valid", bus.rd_valid, exp_rv);
        check_eq("rnd_rd_code", bus.rd_code, exp_rc);
        last_rc = exp_rc;
        if (exp_ack) begin
          if (!pe) model[addr(px, py)] = pc;
          pend = 0;
          cool = 1;
          bus.wr_req = 1'b0;
        end
      end
      bus.rd_en = 1'b0;
      bus.wr_req = 1'b0;
      tick();
    end

    // Clear restarted mid-sweep with a smaller board.
    bus.button_num = 5'd8;
    bus.clr_start = 1'b1;
    tick();
    bus.clr_start = 1'b0;
    check_eq("clr_busy", bus.busy, 1);
    pre_ack = 0;
    for (int k = 0; k < 37; k++) begin
      tick();
      if (bus.clr_done) pre_ack++;
    end
    check_eq("clr_no_early_done", pre_ack, 0);
    sweep_model(8, 37);
    bus.button_num = 5'd4;
    bus.clr_start = 1'b1;
    tick();
    bus.clr_start = 1'b0;
    wait_clr(200, cyc, bl);
    check_eq("clr_restart_cycles", cyc, 16);
    check_eq("clr_restart_busy", bl, 0);
    sweep_model(4, 16);
    for (int y = 0; y < 10; y++)
      for (int x = 0; x < 10; x++) do_read(x, y);

    // Empty board: one CLEAR cycle.
    bus.button_num = 5'd0;
    bus.clr_start = 1'b1;
    tick();
    bus.clr_start = 1'b0;
    check_eq("clr_n0_busy", bus.busy, 1);
    wait_clr(10, cyc, bl);
    check_eq("clr_n0_cycles", cyc, 1);

    // Reset while a write is pending.
    bus.button_num = 5'd10;
    bus.rd_en = 1'b1;
    bus.rd_x = 5'd0;
    bus.rd_y = 5'd0;
    bus.wr_req = 1'b1;
    bus.wr_x = 5'd2;
    bus.wr_y = 5'd2;
    bus.wr_code = 4'h9;
    pre_ack = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (bus.wr_ack) pre_ack++;
    end
    rst = 1'b1;
    tick();
    if (bus.wr_ack) pre_ack++;
    check_eq("rst_pend_busy", bus.busy, 1);
    rst = 1'b0;
    bus.rd_en = 1'b0;
    done_k = -1;
    ack_k = -1;
    for (int k = 1; k <= 400; k++) begin
      tick();
      if (bus.clr_done) done_k = k;
      if (bus.wr_ack) begin
        ack_k = k;
        break;
      end
    end
    bus.wr_req = 1'b0;
    check_eq("rst_pend_no_ack", pre_ack, 0);
    check_eq("rst_pend_clr_done", done_k, 100);
    check_eq("rst_pend_ack_after_clear", ack_k, 101);
    sweep_model(10, 100);
    model[addr(2, 2)] = 4'h9;
    tick();
    do_read(2, 2);
    do_read(9, 9);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
